// File: rtl/usbf_biu_pkg.sv
// Shared definitions for the USB function bus-interface unit: bridge states,
// AHB transfer/response/size codes and a small transfer-type helper.
package usbf_biu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_DONE   = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } biu_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // NONSEQ and SEQ carry data; IDLE and BUSY do not.
  function automatic logic is_active_trans(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/usbf_biu_be_dec.sv
// Combinational legality check (range, size, alignment) and byte-enable
// decode for one AHB address phase.
module usbf_biu_be_dec
  import usbf_biu_pkg::*;
#(
  parameter int CSR_WORDS  = 64,
  parameter int SUBWORD_EN = 1
) (
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  output logic        legal,
  output logic [3:0]  be
);

  logic in_range;
  logic size_ok;
  logic align_ok;

  // Classify the transfer and derive its byte lanes.
  always_comb begin
    in_range = ({2'b00, haddr[31:2]} < 32'(CSR_WORDS));
    size_ok  = 1'b0;
    align_ok = 1'b0;
    be       = 4'h0;
    case (hsize)
      HSIZE_BYTE: begin
        size_ok  = (SUBWORD_EN != 0);
        align_ok = 1'b1;
        be       = 4'b0001 << haddr[1:0];
      end
      HSIZE_HALF: begin
        size_ok  = (SUBWORD_EN != 0);
        align_ok = ~haddr[0];
        be       = haddr[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        size_ok  = 1'b1;
        align_ok = (haddr[1:0] == 2'b00);
        be       = 4'b1111;
      end
      default: begin
      end
    endcase
    legal = in_range & size_ok & align_ok;
  end

endmodule

// File: rtl/usbf_ahb_csr_bridge.sv
// AHB-lite slave to simple CSR request/ack bridge with access timeout and
// the two-cycle AHB error response.
//
//  state  | meaning
//  IDLE   | no transfer in flight, zero-wait OKAY
//  ACCESS | CSR request outstanding, AHB stalled
//  DONE   | CSR acked, completing data phase with OKAY
//  ERR1   | first ERROR cycle (hready low)
//  ERR2   | second ERROR cycle (hready high)
module usbf_ahb_csr_bridge
  import usbf_biu_pkg::*;
#(
  parameter int CSR_WORDS   = 64,
  parameter int TIMEOUT_CYC = 16,
  parameter int SUBWORD_EN  = 1,
  localparam int AW = $clog2(CSR_WORDS),
  localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          hclk_i,
  input  logic          hrst_i,
  input  logic          hsel_i,
  input  logic          hwrite_i,
  input  logic [1:0]    htrans_i,
  input  logic [2:0]    hsize_i,
  input  logic [31:0]   haddr_i,
  input  logic [31:0]   hwdata_i,
  input  logic          hready_i,
  output logic          hready_o,
  output logic [1:0]    hresp_o,
  output logic [31:0]   hrdata_o,
  output logic          csr_req_o,
  output logic          csr_we_o,
  output logic [AW-1:0] csr_addr_o,
  output logic [3:0]    csr_be_o,
  output logic [31:0]   csr_wdata_o,
  input  logic          csr_ack_i,
  input  logic          csr_err_i,
  input  logic [31:0]   csr_rdata_i
);

  biu_state_e    state;
  logic [TW-1:0] tmo_cnt;
  logic          addr_valid;
  logic          legal;
  logic [3:0]    be;

  usbf_biu_be_dec #(
    .CSR_WORDS  (CSR_WORDS),
    .SUBWORD_EN (SUBWORD_EN)
  ) u_be_dec (
    .haddr (haddr_i),
    .hsize (hsize_i),
    .legal (legal),
    .be    (be)
  );

  assign addr_valid  = hsel_i & hready_i & is_active_trans(htrans_i);
  // Write data belongs to the data phase, which is exactly the ACCESS window.
  assign csr_wdata_o = hwdata_i;

  // Sequencer; all AHB and CSR outputs are registered alongside the state.
  always_ff @(posedge hclk_i) begin
    if (hrst_i) begin
      state      <= ST_IDLE;
      hready_o   <= 1'b1;
      hresp_o    <= HRESP_OKAY;
      hrdata_o   <= '0;
      csr_req_o  <= 1'b0;
      csr_we_o   <= 1'b0;
      csr_addr_o <= '0;
      csr_be_o   <= 4'h0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR2: begin
          if (addr_valid) begin
            csr_we_o   <= hwrite_i;
            csr_addr_o <= haddr_i[AW+1:2];
            csr_be_o   <= be;
            hready_o   <= 1'b0;
            if (legal) begin
              state     <= ST_ACCESS;
              hresp_o   <= HRESP_OKAY;
              csr_req_o <= 1'b1;
              tmo_cnt   <= TW'(TIMEOUT_CYC);
            end else begin
              state     <= ST_ERR1;
              hresp_o   <= HRESP_ERROR;
              csr_req_o <= 1'b0;
            end
          end else begin
            state     <= ST_IDLE;
            hready_o  <= 1'b1;
            hresp_o   <= HRESP_OKAY;
            csr_req_o <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (csr_ack_i) begin
            csr_req_o <= 1'b0;
            tmo_cnt   <= '0;
            if (csr_err_i) begin
              state   <= ST_ERR1;
              hresp_o <= HRESP_ERROR;
            end else begin
              state    <= ST_DONE;
              hready_o <= 1'b1;
              hresp_o  <= HRESP_OKAY;
              if (!csr_we_o) hrdata_o <= csr_rdata_i;
            end
          end else if (tmo_cnt == TW'(1)) begin
            state     <= ST_ERR1;
            hresp_o   <= HRESP_ERROR;
            csr_req_o <= 1'b0;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_o <= 1'b1;
          hresp_o  <= HRESP_ERROR;
        end
        default: begin
          state     <= ST_IDLE;
          hready_o  <= 1'b1;
          hresp_o   <= HRESP_OKAY;
          csr_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/usbf_ahb_csr_bridge.md
USBF_AHB_CSR_BRIDGE -- requirements
Module: usbf_ahb_csr_bridge

Interface
REQ-001 SHALL have parameter CSR_WORDS, default 64: number of 32-bit CSR words; legal word index 0..CSR_WORDS-1.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16: maximum ACCESS cycles before an ERROR response; legal range 1..255.
REQ-003 SHALL have parameter SUBWORD_EN, default 1: 1 = byte/halfword transfers allowed; 0 = any hsize other than word answers ERROR.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have ports hclk_i in 1 clock; hrst_i in 1 synchronous active-high reset.
REQ-006 SHALL have AHB ports hsel_i in 1; hwrite_i in 1; htrans_i in 2; hsize_i in 3; haddr_i in 32; hwdata_i in 32; hready_i in 1; hready_o out 1; hresp_o out 2; hrdata_o out 32.
REQ-007 SHALL have CSR ports csr_req_o out 1; csr_we_o out 1; csr_addr_o out $clog2(CSR_WORDS) word index; csr_be_o out 4 byte enables; csr_wdata_o out 32; csr_ack_i in 1; csr_err_i in 1 (qualified by csr_ack_i); csr_rdata_i in 32.

Function
REQ-008 SHALL treat a valid address phase as hsel_i & hready_i & htrans_i[1]; IDLE/BUSY transfers and hsel_i low SHALL get a zero-wait OKAY and no CSR access.
REQ-009 SHALL implement states IDLE, ACCESS, DONE, ERR1, ERR2.
REQ-010 SHALL, in IDLE, DONE and ERR2, accept a valid address phase: legal -> ACCESS; illegal -> ERR1; otherwise -> IDLE.
REQ-011 SHALL register hwrite_i, word index haddr_i[31:2], and byte enables at the address phase.
REQ-012 SHALL classify a transfer as illegal when: word index >= CSR_WORDS; hsize_i > 2; halfword with haddr_i[0]=1; word with haddr_i[1:0]!=0; or SUBWORD_EN=0 and hsize_i != 2.
REQ-013 SHALL decode byte enables as: byte -> 1<<haddr_i[1:0]; halfword -> 4'b0011 or 4'b1100 by haddr_i[1]; word -> 4'b1111.
REQ-014 SHALL, in ACCESS, drive csr_req_o=1 with stable csr_we_o, csr_addr_o and csr_be_o, drive csr_wdata_o=hwdata_i, and drive hready_o=0 with hresp_o=OKAY.
REQ-015 SHALL, in ACCESS with csr_ack_i=1 and csr_err_i=0, latch csr_rdata_i (reads only) and go to DONE.
REQ-016 SHALL, in ACCESS with csr_ack_i=1 and csr_err_i=1, go to ERR1.
REQ-017 SHALL count ACCESS cycles; when the count reaches TIMEOUT_CYC with no ack, go to ERR1 and deassert csr_req_o; an ack in that same cycle SHALL take priority.
REQ-018 SHALL, in DONE, drive hready_o=1, hresp_o=OKAY and hrdata_o=latched data; a zero-wait CSR therefore gives a 2-cycle data phase.
REQ-019 SHALL drive hready_o=0 with hresp_o=ERROR in ERR1, then hready_o=1 with hresp_o=ERROR in ERR2 (the AHB two-cycle error response).
REQ-020 SHALL ignore csr_ack_i outside ACCESS.
REQ-021 SHALL assert csr_req_o for exactly one access per accepted transfer and SHALL NOT re-issue it.
REQ-022 SHALL hold hrdata_o at its last value outside DONE.

Reset
REQ-023 SHALL, on hrst_i=1 at a clock edge: state=IDLE, hready_o=1, hresp_o=OKAY, csr_req_o=0, csr_we_o=0, csr_be_o=0, timeout counter=0, hrdata_o=0.
REQ-024 SHALL, on reset during ACCESS, drop csr_req_o on that edge; a later stray ack SHALL be ignored under REQ-020.

Structure
REQ-025 SHALL take from shared package usbf_biu_pkg: state enum, HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HRESP codes (OKAY=0, ERROR=1), HSIZE codes.
REQ-026 SHALL place size/alignment/range legality and byte-enable decode in sub-module usbf_biu_be_dec, which is purely combinational.
REQ-027 SHALL size the timeout counter to $clog2(TIMEOUT_CYC+1) bits.

Verification
REQ-028 Word write 0xA5A5_1234 to haddr 0x10, ack on the first ACCESS cycle -> csr_addr_o=4, csr_be_o=4'hF, csr_wdata_o matches, one hready_o=0 cycle, OKAY.
REQ-029 Byte read at 0x23, csr_rdata_i=0x1122_3344 with ack after 3 cycles -> csr_be_o=4'b1000, hready_o low 4 cycles, hrdata_o=0x1122_3344 in DONE.
REQ-030 Word read at 0x100 (index 64 >= CSR_WORDS) -> no csr_req_o, ERR1 then ERR2 with ERROR; halfword at 0x01 -> same.
REQ-031 Read with no ack, TIMEOUT_CYC=16 -> csr_req_o high exactly 16 cycles, then ERROR pair; a late ack is ignored.
REQ-032 Back-to-back NONSEQ writes, second address phase during DONE -> second access proceeds with no idle cycle; hrst_i pulsed mid-ACCESS -> IDLE, csr_req_o=0 on the next edge.
